// File: rtl/lms_pkg.sv
// Shared widths, types and helpers for the LMS adaptive FIR blocks.
package lms_pkg;

    localparam int X_W    = 8;
    localparam int H_W    = 8;
    localparam int E_W    = 10;
    localparam int P_W    = 16;
    localparam int S_W    = 18;
    localparam int N_TAPS = 4;

    typedef logic signed [X_W-1:0] sample_t;
    typedef logic signed [H_W-1:0] coef_t;
    typedef logic signed [P_W-1:0] prod_t;
    typedef logic signed [S_W-1:0] sum_t;
    typedef logic signed [E_W-1:0] err_t;

    localparam sample_t SAMPLE_MAX = sample_t'(127);
    localparam sample_t SAMPLE_MIN = sample_t'(-128);

    // Clamp a wide accumulator value into the 8-bit sample range.
    function automatic sample_t sat8(input sum_t v);
        if (v > sum_t'(SAMPLE_MAX)) begin
            return SAMPLE_MAX;
        end else if (v < sum_t'(SAMPLE_MIN)) begin
            return SAMPLE_MIN;
        end else begin
            return sample_t'(v);
        end
    endfunction

endpackage

// File: rtl/lms_fir_datapath_tap_line.sv
// Tap delay line of the LMS FIR plus a saturating fill counter that tells
// whether the sample being accepted now completes a full line.
module lms_tap_line
    import lms_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    shift,
    input  sample_t din,
    output sample_t t0,
    output sample_t t1,
    output sample_t t2,
    output sample_t t3,
    output logic    full
);

    logic [2:0] count;

    // Shift a new sample in on each accepted input and count up to four.
    always_ff @(posedge clk) begin
        if (rst) begin
            t0    <= '0;
            t1    <= '0;
            t2    <= '0;
            t3    <= '0;
            count <= '0;
        end else if (shift) begin
            t0 <= din;
            t1 <= t0;
            t2 <= t1;
            t3 <= t2;
            if (count != 3'd4) begin
                count <= count + 3'd1;
            end
        end
    end

    // Three earlier samples already held means the incoming one fills the line.
    assign full = (count >= 3'd3);

endmodule

// File: rtl/lms_fir_datapath.sv
// Forward datapath of the 4-tap LMS FIR: delay line, products, saturated
// output and the error handed to the weight-update block with its taps.
module lms_fir_datapath
    import lms_pkg::*;
#(
    parameter int Y_SHIFT = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    in_valid,
    input  sample_t xn,
    input  sample_t dn,
    input  logic    adapt_en,
    input  coef_t   hn0,
    input  coef_t   hn1,
    input  coef_t   hn2,
    input  coef_t   hn3,
    output sample_t yn,
    output err_t    errr,
    output sample_t xd0,
    output sample_t xd1,
    output sample_t xd2,
    output sample_t xd3,
    output logic    out_valid
);

    sample_t t0, t1, t2, t3;
    logic    full;

    lms_tap_line u_tap_line (
        .clk   (clk),
        .rst   (rst),
        .shift (in_valid),
        .din   (xn),
        .t0    (t0),
        .t1    (t1),
        .t2    (t2),
        .t3    (t3),
        .full  (full)
    );

    sample_t taps [N_TAPS];
    coef_t   w    [N_TAPS];

    assign taps[0] = t0;
    assign taps[1] = t1;
    assign taps[2] = t2;
    assign taps[3] = t3;
    assign w[0]    = hn0;
    assign w[1]    = hn1;
    assign w[2]    = hn2;
    assign w[3]    = hn3;

    logic    s0_valid;
    sample_t s0_dn;
    logic    s0_adapt;

    // Tag the sample entering the line with its validity, desired value and adapt flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_dn    <= '0;
            s0_adapt <= 1'b0;
        end else begin
            s0_valid <= in_valid & full;
            s0_dn    <= dn;
            s0_adapt <= adapt_en;
        end
    end

    prod_t   p       [N_TAPS];
    sample_t s1_taps [N_TAPS];
    logic    s1_valid;
    sample_t s1_dn;
    logic    s1_adapt;

    // Register tap-by-weight products together with the taps that formed them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_TAPS; k++) begin
                p[k]       <= '0;
                s1_taps[k] <= '0;
            end
            s1_valid <= 1'b0;
            s1_dn    <= '0;
            s1_adapt <= 1'b0;
        end else begin
            for (int k = 0; k < N_TAPS; k++) begin
                p[k]       <= prod_t'(taps[k]) * prod_t'(w[k]);
                s1_taps[k] <= taps[k];
            end
            s1_valid <= s0_valid;
            s1_dn    <= s0_dn;
            s1_adapt <= s0_adapt;
        end
    end

    sum_t    sum_c;
    sum_t    sum_shift;
    sample_t y_c;
    err_t    err_c;

    // Sum the products, scale, saturate and form the (optionally frozen) error.
    always_comb begin
        sum_c = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            sum_c = sum_c + sum_t'(p[k]);
        end
        sum_shift = sum_c >>> Y_SHIFT;
        y_c       = sat8(sum_shift);
        err_c     = s1_adapt ? (err_t'(s1_dn) - err_t'(y_c)) : '0;
    end

    // Publish results on a valid sample; yn/xd hold, errr drops to zero otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            yn        <= '0;
            errr      <= '0;
            xd0       <= '0;
            xd1       <= '0;
            xd2       <= '0;
            xd3       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                yn   <= y_c;
                errr <= err_c;
                xd0  <= s1_taps[0];
                xd1  <= s1_taps[1];
                xd2  <= s1_taps[2];
                xd3  <= s1_taps[3];
            end else begin
                errr <= '0;
            end
        end
    end

endmodule
